// File: rtl/except_ctrl_pkg.sv
// except_ctrl_pkg: exception codes, flag bits, CP0 addresses and FSM states
package except_ctrl_pkg;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_INVALID = 32'ha;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_ERET    = 32'he;
  localparam int FLAG_SYSCALL = 8;
  localparam int FLAG_INVALID = 9;
  localparam int FLAG_TRAP    = 10;
  localparam int FLAG_OV      = 11;
  localparam int FLAG_ERET    = 12;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  typedef enum logic {IDLE, SUPPRESS} state_t;
endpackage

// File: rtl/except_ctrl_int_sync.sv
// int_sync: multi-flop synchroniser for the asynchronous external interrupt lines
module int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d,
  output logic [4:0] q
);
  logic [SYNC_STAGES-1:0][4:0] chain;
  always_ff @(posedge clk)
    if (rst) chain <= '0;
    else chain <= {chain[SYNC_STAGES-2:0], d};
  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: prioritises MEM-stage exceptions and interrupts, drives CP0 and pipeline flush/redirect
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR      = 32'h00000020,
  parameter int          SYNC_STAGES     = 2,
  parameter int          SUPPRESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  int_raw_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_sync_o,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_is_in_delayslot_i,
  input  logic [31:0] mem_except_flags_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);
  logic [4:0] int_q;
  logic [31:0] status_eff, cause_eff, epc_eff, code;
  logic int_pend, active;
  logic [1:0] cnt, cnt_nxt;
  state_t state, state_nxt;
  logic unused;

  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (.clk(clk), .rst(rst), .d(int_raw_i), .q(int_q));
  assign int_sync_o = {timer_int_i, int_q};

  // A pending WB write to CP0 is visible here in the same cycle it retires
  assign status_eff = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_data_i : cp0_status_i;
  assign epc_eff    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC) ? wb_cp0_data_i : cp0_epc_i;
  assign cause_eff  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE)
    ? {cp0_cause_i[31:24], wb_cp0_data_i[23:22], cp0_cause_i[21:10], wb_cp0_data_i[9:8], cp0_cause_i[7:0]}
    : cp0_cause_i;

  assign int_pend = status_eff[ST_IE] & ~status_eff[ST_EXL] & |(cause_eff[15:8] & status_eff[15:8]);
  assign active   = !rst && state == IDLE && mem_pc_i != 32'h0;

  always_comb begin
    code = int_pend                         ? EXC_INT
         : mem_except_flags_i[FLAG_SYSCALL] ? EXC_SYSCALL
         : mem_except_flags_i[FLAG_INVALID] ? EXC_INVALID
         : mem_except_flags_i[FLAG_TRAP]    ? EXC_TRAP
         : mem_except_flags_i[FLAG_OV]      ? EXC_OV
         : mem_except_flags_i[FLAG_ERET]    ? EXC_ERET
         : 32'h0;
    excepttype_o = active ? code : 32'h0;
    flush_o      = excepttype_o != 32'h0;
    new_pc_o     = !flush_o ? 32'h0 : (excepttype_o == EXC_ERET ? epc_eff : EXC_VECTOR);
  end

  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_is_in_delayslot_i;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE && flush_o) begin
      state_nxt = SUPPRESS;
      cnt_nxt   = 2'(SUPPRESS_CYCLES);
    end else if (state == SUPPRESS) begin
      cnt_nxt   = cnt - 2'd1;
      state_nxt = cnt <= 2'd1 ? IDLE : SUPPRESS;
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  assign unused = ^{mem_except_flags_i[31:13], mem_except_flags_i[7:0], status_eff[31:16], status_eff[7:2],
                    cause_eff[31:16], cause_eff[7:0]};
endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl: directed scoreboard bench for except_ctrl
module tb_except_ctrl;
  logic clk = 0, rst = 1;
  logic [4:0] int_raw_i = 0;
  logic timer_int_i = 0;
  logic [5:0] int_sync_o;
  logic [31:0] mem_pc_i = 0, mem_except_flags_i = 0, cp0_status_i = 0, cp0_cause_i = 0, cp0_epc_i = 0;
  logic mem_is_in_delayslot_i = 0, wb_cp0_we_i = 0;
  logic [4:0] wb_cp0_waddr_i = 0;
  logic [31:0] wb_cp0_data_i = 0;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic is_in_delayslot_o, flush_o;
  int checks = 0, passes = 0;

  typedef struct {string tag; int sel; logic [31:0] val;} exp_t;
  exp_t sb[$];

  except_ctrl dut (
    .clk(clk), .rst(rst), .int_raw_i(int_raw_i), .timer_int_i(timer_int_i), .int_sync_o(int_sync_o),
    .mem_pc_i(mem_pc_i), .mem_is_in_delayslot_i(mem_is_in_delayslot_i), .mem_except_flags_i(mem_except_flags_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return excepttype_o;
      1: return {31'h0, flush_o};
      2: return new_pc_o;
      3: return {26'h0, int_sync_o};
      4: return current_inst_addr_o;
      default: return {31'h0, is_in_delayslot_o};
    endcase
  endfunction

  task automatic expect_val(string tag, int sel, logic [31:0] v);
    sb.push_back('{tag, sel, v});
  endtask

  task automatic expect_exc(string tag, logic [31:0] et, logic [31:0] pc);
    expect_val({tag, ".type"}, 0, et);
    expect_val({tag, ".flush"}, 1, {31'h0, et != 0});
    expect_val({tag, ".newpc"}, 2, pc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] o;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) passes++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
    end
  endtask

  task automatic idle_bubble();
    mem_pc_i = 0; mem_except_flags_i = 0; wb_cp0_we_i = 0; mem_is_in_delayslot_i = 0;
  endtask

  initial begin
    int_raw_i = 5'h1f;
    repeat (2) next_cycle();
    next_cycle();
    timer_int_i = 1;
    expect_val("rst.int_sync", 3, 32'h20);
    expect_exc("rst", 32'h0, 32'h0);
    check_all();
    next_cycle();
    rst = 0; timer_int_i = 0;
    expect_val("sync0", 3, 32'h0);
    check_all();
    next_cycle();
    expect_val("sync1", 3, 32'h0);
    check_all();
    next_cycle();
    expect_val("sync2", 3, 32'h1f);
    check_all();
    next_cycle();
    int_raw_i = 0;
    mem_pc_i = 32'h100; mem_except_flags_i = 32'h100; cp0_status_i = 32'h1000_0000;
    expect_exc("syscall", 32'h8, 32'h20);
    expect_val("syscall.addr", 4, 32'h100);
    expect_val("syscall.ds", 5, 32'h0);
    check_all();
    next_cycle();
    expect_exc("suppress", 32'h0, 32'h0);
    check_all();
    next_cycle();
    expect_exc("syscall2", 32'h8, 32'h20);
    check_all();
    next_cycle();
    idle_bubble();
    expect_exc("clr1", 32'h0, 32'h0);
    check_all();
    next_cycle();
    mem_pc_i = 32'h104; mem_except_flags_i = 32'h1000; cp0_epc_i = 32'h40;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h80;
    expect_exc("eret.fwd", 32'he, 32'h80);
    check_all();
    next_cycle();
    wb_cp0_we_i = 0;
    expect_exc("eret.supp", 32'h0, 32'h0);
    check_all();
    next_cycle();
    expect_exc("eret.nofwd", 32'he, 32'h40);
    check_all();
    next_cycle();
    idle_bubble();
    expect_exc("clr2", 32'h0, 32'h0);
    check_all();
    next_cycle();
    mem_pc_i = 32'h108; cp0_cause_i = 32'h400; cp0_status_i = 32'h1000_0401;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h1000_0400;
    expect_exc("int.masked", 32'h0, 32'h0);
    check_all();
    next_cycle();
    wb_cp0_we_i = 0;
    expect_exc("int", 32'h1, 32'h20);
    check_all();
    next_cycle();
    expect_exc("int.supp", 32'h0, 32'h0);
    check_all();
    next_cycle();
    mem_pc_i = 32'h10c; mem_except_flags_i = 32'h0a00; mem_is_in_delayslot_i = 1;
    expect_exc("prio", 32'h1, 32'h20);
    expect_val("prio.ds", 5, 32'h1);
    check_all();
    next_cycle();
    idle_bubble();
    expect_exc("bub.supp", 32'h0, 32'h0);
    check_all();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      expect_exc("bubble", 32'h0, 32'h0);
      check_all();
    end
    next_cycle();
    mem_pc_i = 32'h200;
    expect_exc("bub.take", 32'h1, 32'h20);
    check_all();
    next_cycle();
    idle_bubble(); cp0_cause_i = 0; cp0_status_i = 32'h1000_0000;
    expect_exc("clr3", 32'h0, 32'h0);
    check_all();
    next_cycle();
    mem_pc_i = 32'h300; mem_except_flags_i = 32'h1e00;
    expect_exc("invalid", 32'ha, 32'h20);
    check_all();
    next_cycle();
    idle_bubble();
    check_all();
    next_cycle();
    mem_pc_i = 32'h304; mem_except_flags_i = 32'h1c00;
    expect_exc("trap", 32'hd, 32'h20);
    check_all();
    next_cycle();
    idle_bubble();
    check_all();
    next_cycle();
    mem_pc_i = 32'h308; mem_except_flags_i = 32'h18ff;
    expect_exc("ov", 32'hc, 32'h20);
    check_all();
    next_cycle();
    idle_bubble();
    check_all();
    next_cycle();
    mem_pc_i = 32'h30c; cp0_status_i = 32'h1000_0101;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h0000_0100;
    expect_exc("cause.fwd", 32'h1, 32'h20);
    check_all();
    next_cycle();
    rst = 1;
    expect_exc("rst.mid", 32'h0, 32'h0);
    check_all();
    next_cycle();
    rst = 0;
    expect_exc("rst.after", 32'h1, 32'h20);
    check_all();
    next_cycle();
    idle_bubble();
    check_all();
    next_cycle();
    mem_pc_i = 32'h310; cp0_status_i = 32'h1000_0403; cp0_cause_i = 32'h400;
    expect_exc("exl", 32'h0, 32'h0);
    check_all();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception initiator feeding the CP0 register block.
- Sits beside the MEM stage. It synchronises external interrupt lines into the CP0 int_i field and prioritises MEM-stage exception flags against forwarded Status/Cause.
- Drives excepttype, current instruction address and delay-slot flag to CP0.
- Issues pipeline flush plus redirect PC to the fetch stage.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for every exception except ERET.
- SYNC_STAGES, 2, flip-flop depth of the external interrupt synchroniser (>=2).
- SUPPRESS_CYCLES, 1, cycles after a flush during which no new exception may be raised (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- int_raw_i  in  5  asynchronous external interrupt lines (hw int 0..4)
- timer_int_i  in  1  CP0 timer interrupt, already synchronous
- int_sync_o  out  6  to CP0 int_i: {timer_int_i, synchronised int_raw_i}
- mem_pc_i  in  32  MEM-stage instruction address; 0 means bubble
- mem_is_in_delayslot_i  in  1  MEM instruction sits in a delay slot
- mem_except_flags_i  in  32  bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret; other bits ignored
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values
- wb_cp0_we_i  in  1  WB-stage CP0 write pending
- wb_cp0_waddr_i  in  5  its address (12 status, 13 cause, 14 epc)
- wb_cp0_data_i  in  32  its data
- excepttype_o  out  32  to CP0 excepttype_i
- current_inst_addr_o  out  32  to CP0, equals mem_pc_i
- is_in_delayslot_o  out  1  to CP0, equals mem_is_in_delayslot_i
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Reset: sync chain cleared and int_sync_o[4:0]=0. FSM=IDLE, suppress counter=0, excepttype_o=0, flush_o=0, new_pc_o=0.
  - int_sync_o[5] follows timer_int_i even during reset.
- Synchroniser:
  - int_raw_i reaches int_sync_o[4:0] exactly SYNC_STAGES edges after sampling.
  - No combinational path from int_raw_i.
- Forwarding. The effective values are:
  - status_eff = wb_cp0_data_i if wb_cp0_we_i and waddr=12, else cp0_status_i.
  - epc_eff: same rule at waddr 14.
  - cause_eff = cp0_cause_i with bits [9:8] and [23:22] replaced from wb_cp0_data_i when we and waddr=13. Only these bits are software-writable.
- Detection (combinational, same cycle as MEM):
  - Active only when FSM=IDLE and mem_pc_i!=0. Otherwise excepttype_o=0.
  - Interrupt pending = status_eff[0]=1 AND status_eff[1]=0 AND (cause_eff[15:8] & status_eff[15:8])!=0.
  - Priority, highest first:
    - interrupt -> 32'h1
    - syscall -> 32'h8
    - invalid -> 32'ha
    - trap -> 32'hd
    - overflow -> 32'hc
    - eret -> 32'he
  - Exactly one code is emitted; lower-priority flags are dropped.
- Flush (combinational with detection):
  - flush_o=1 whenever excepttype_o!=0.
  - new_pc_o = epc_eff for 32'he, else EXC_VECTOR.
  - When flush_o=0, new_pc_o=0.
- FSM:
  - IDLE -> SUPPRESS on any edge with flush_o=1; the counter loads SUPPRESS_CYCLES.
  - SUPPRESS decrements the counter each cycle, forces excepttype_o=0 and flush_o=0, and returns to IDLE when the counter reaches 1.
  - Interrupts arriving during SUPPRESS stay pending and are taken on the first IDLE cycle with a valid MEM instruction.
- Bubbles:
  - A pending interrupt while mem_pc_i=0 is held off, not lost. It is re-evaluated every cycle since it is level-based.
- Simultaneous events:
  - An interrupt plus a synchronous flag on the same instruction yields 32'h1.
  - A WB write to Status clearing IE in the same cycle masks the interrupt, because forwarding wins.
- Reset mid-SUPPRESS returns the FSM to IDLE on the next edge, with no flush.

Decomposition:
- Shared package/defines:
  - excepttype codes 1/8/a/d/c/e
  - flag bit indices 8..12
  - CP0 addresses 12/13/14
  - Status IE/EXL bit positions
- Sub-module int_sync (parameter SYNC_STAGES, width 5): a pure flop chain, kept separate for CDC lint waivers.

Test Plan:
- Reset: hold rst 3 cycles with int_raw_i=5'h1f -> int_sync_o[4:0]=0, flush_o=0; after release with SYNC_STAGES=2, int_sync_o[4:0]=5'h1f two edges later.
- Syscall: mem_pc_i=32'h100, flags bit8, status=32'h1000_0000 -> excepttype_o=32'h8, flush_o=1, new_pc_o=32'h20, current_inst_addr_o=32'h100; next cycle flush_o=0 (SUPPRESS) even with flags still set.
- ERET forwarding: cp0_epc_i=32'h40, WB writes EPC=32'h80 same cycle, flags bit12 -> excepttype_o=32'he, new_pc_o=32'h80.
- Interrupt masking: cause[10]=1, status=32'h1000_0401 -> excepttype_o=1; same plus WB writing status=32'h1000_0400 -> excepttype_o=0, flush_o=0.
- Priority: status=32'h1000_0401, cause[10]=1, flags bits 9 and 11 set, delayslot=1 -> excepttype_o=32'h1, is_in_delayslot_o=1.
- Bubble hold-off: interrupt pending, mem_pc_i=0 for 4 cycles -> no flush; first cycle with mem_pc_i=32'h200 -> excepttype_o=32'h1, flush_o=1.
